// File: rtl/cordic_share_arbiter_pkg.sv
// Shared definitions for the CORDIC share arbiter: FSM encodings, requester
// indices and the round-robin tie-break helper.
package cordic_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // On a tie the port that did not win last time gets the grant.
    function automatic logic rr_pick(input logic last_grant);
        return (last_grant == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/cordic_share_arbiter_if.sv
// AXI-Stream style channel (data, last, valid, ready) used for every stream
// port of the CORDIC share arbiter.
interface cordic_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/cordic_share_arbiter_tag_fifo.sv
// One-bit tag FIFO remembering which requester owns each packet inside the
// shared CORDIC; count is the registered occupancy that drives full/empty.
module tag_fifo
    import cordic_share_arbiter_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                push_tag,
    input  logic                pop,
    output logic                head_tag,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH-1:0]      mem;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_tag = mem[rd_ptr];
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);

endmodule

// File: rtl/cordic_share_arbiter.sv
// Packet-level round-robin arbiter sharing one CORDIC between two requesters,
// routing returning results back by a FIFO of grant tags.
module cordic_share_arbiter
    import cordic_share_arbiter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TAG_DEPTH_LOG2 = 2
) (
    input  logic                      ce_clk,
    input  logic                      ce_rst,
    cordic_share_arbiter_if.slave     s0,
    cordic_share_arbiter_if.slave     s1,
    cordic_share_arbiter_if.master    c,
    cordic_share_arbiter_if.slave     r,
    cordic_share_arbiter_if.master    o0,
    cordic_share_arbiter_if.master    o1,
    output logic [TAG_DEPTH_LOG2:0]   inflight,
    output logic                      busy
);

    arb_state_t       state, state_next;
    logic             last_grant;
    logic             push, push_tag, pop;
    logic             head_tag, full, empty;
    logic [WIDTH-1:0] c_data_mux;

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            state      <= IDLE;
            last_grant <= PORT1;
        end else begin
            state <= state_next;
            if (push) begin
                last_grant <= push_tag;
            end
        end
    end

    // Grants are only decided in IDLE, which costs one bubble cycle per packet.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_tag   = PORT0;
        c_data_mux = s0.tdata;
        c.tlast    = s0.tlast;
        c.tvalid   = 1'b0;
        s0.tready  = 1'b0;
        s1.tready  = 1'b0;
        case (state)
            IDLE: begin
                if (!full && (s0.tvalid || s1.tvalid)) begin
                    push = 1'b1;
                    if (s0.tvalid && s1.tvalid) begin
                        push_tag = rr_pick(last_grant);
                    end else begin
                        push_tag = s1.tvalid ? PORT1 : PORT0;
                    end
                    state_next = (push_tag == PORT1) ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                c.tvalid  = s0.tvalid;
                s0.tready = c.tready;
                if (s0.tvalid && c.tready && s0.tlast) begin
                    state_next = IDLE;
                end
            end
            GRANT1: begin
                c_data_mux = s1.tdata;
                c.tlast    = s1.tlast;
                c.tvalid   = s1.tvalid;
                s1.tready  = c.tready;
                if (s1.tvalid && c.tready && s1.tlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign c.tdata = c_data_mux;

    // Results belong to whichever requester's tag sits at the FIFO head.
    always_comb begin
        o0.tvalid = r.tvalid && !empty && (head_tag == PORT0);
        o1.tvalid = r.tvalid && !empty && (head_tag == PORT1);
        r.tready  = !empty && ((head_tag == PORT1) ? o1.tready : o0.tready);
    end

    assign o0.tdata = r.tdata;
    assign o0.tlast = r.tlast;
    assign o1.tdata = r.tdata;
    assign o1.tlast = r.tlast;

    assign pop  = r.tvalid && r.tready && r.tlast;
    assign busy = (state != IDLE);

    tag_fifo #(
        .DEPTH_LOG2 (TAG_DEPTH_LOG2)
    ) u_tag_fifo (
        .clk      (ce_clk),
        .rst      (ce_rst),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (full),
        .empty    (empty),
        .count    (inflight)
    );

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Bench for cordic_share_arbiter: per-port expected-beat queues checked by a
// monitor against a fixed-latency CORDIC model, plus directed grant checks.
`timescale 1ns/1ps
module tb_cordic_share_arbiter;

    localparam int WIDTH = 32;
    localparam int TDL   = 2;
    localparam int DEPTH = 4;
    localparam int LAT   = 8;

    logic         ce_clk = 1'b0;
    logic         ce_rst = 1'b1;
    logic [TDL:0] inflight;
    logic         busy;

    cordic_share_arbiter_if #(.WIDTH(WIDTH)) s0_if ();
    cordic_share_arbiter_if #(.WIDTH(WIDTH)) s1_if ();
    cordic_share_arbiter_if #(.WIDTH(WIDTH)) c_if ();
    cordic_share_arbiter_if #(.WIDTH(WIDTH)) r_if ();
    cordic_share_arbiter_if #(.WIDTH(WIDTH)) o0_if ();
    cordic_share_arbiter_if #(.WIDTH(WIDTH)) o1_if ();

    cordic_share_arbiter #(.WIDTH(WIDTH), .TAG_DEPTH_LOG2(TDL)) dut (
        .ce_clk   (ce_clk),
        .ce_rst   (ce_rst),
        .s0       (s0_if),
        .s1       (s1_if),
        .c        (c_if),
        .r        (r_if),
        .o0       (o0_if),
        .o1       (o1_if),
        .inflight (inflight),
        .busy     (busy)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct packed {logic [WIDTH-1:0] data; logic last;} beat_t;
    typedef struct packed {logic [WIDTH-1:0] data; logic last; int unsigned due;} cbeat_t;
    typedef struct packed {int unsigned cyc; logic port; logic first; logic last;} glog_t;

    beat_t       exp0[$];
    beat_t       exp1[$];
    cbeat_t      cq[$];
    glog_t       glog[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          model_cnt = 0;
    int          samecyc = 0;
    int          o1_valid_cycles = 0;
    bit          rnd_mode = 0;
    bit          log_en = 0;
    logic        c_first = 1'b1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge ce_clk);
        #1;
    endtask

    // CORDIC return side and random readiness, driven just after each edge.
    always @(posedge ce_clk) begin
        cyc++;
        #1;
        if (rnd_mode) begin
            c_if.tready  = 1'($urandom_range(0, 1));
            o0_if.tready = 1'($urandom_range(0, 1));
            o1_if.tready = 1'($urandom_range(0, 1));
        end
        if (cq.size() != 0 && cq[0].due <= cyc) begin
            r_if.tvalid = 1'b1;
            r_if.tdata  = cq[0].data;
            r_if.tlast  = cq[0].last;
        end else begin
            r_if.tvalid = 1'b0;
        end
    end

    // Monitor: CORDIC intake, occupancy model and per-port scoreboard.
    always @(negedge ce_clk) begin
        beat_t e;
        glog_t g;
        bit    m_push, m_pop;
        if (ce_rst) begin
            cq.delete();
            model_cnt = 0;
            c_first   = 1'b1;
        end else begin
            check("inflight_model", inflight, model_cnt);
            m_push = !busy && (s0_if.tvalid || s1_if.tvalid) && (model_cnt < DEPTH);
            m_pop  = r_if.tvalid && r_if.tready && r_if.tlast;
            if (m_push && m_pop) samecyc++;
            model_cnt = model_cnt + int'(m_push) - int'(m_pop);
            if (o1_if.tvalid) o1_valid_cycles++;
            if (c_if.tvalid && c_if.tready) begin
                cq.push_back(cbeat_t'{c_if.tdata, c_if.tlast, cyc + LAT});
                if (log_en) begin
                    g.cyc   = cyc;
                    g.port  = (c_if.tdata[31:28] == 4'hB);
                    g.first = c_first;
                    g.last  = c_if.tlast;
                    glog.push_back(g);
                end
                c_first = c_if.tlast;
            end
            if (r_if.tvalid && r_if.tready && cq.size() != 0) void'(cq.pop_front());
            if (o0_if.tvalid && o0_if.tready) begin
                if (exp0.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL o0_unexpected: actual %0h required no beat", o0_if.tdata);
                end else begin
                    e = exp0.pop_front();
                    check("o0_data", o0_if.tdata, e.data);
                    check("o0_last", o0_if.tlast, e.last);
                end
            end
            if (o1_if.tvalid && o1_if.tready) begin
                if (exp1.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL o1_unexpected: actual %0h required no beat", o1_if.tdata);
                end else begin
                    e = exp1.pop_front();
                    check("o1_data", o1_if.tdata, e.data);
                    check("o1_last", o1_if.tlast, e.last);
                end
            end
        end
    end

    task automatic send_pkt(input int port, input int len, input logic [WIDTH-1:0] base);
        beat_t b;
        bit    acc;
        int    t;
        for (int i = 0; i < len; i++) begin
            b.data = base + i;
            b.last = (i == len - 1);
            if (port == 0) exp0.push_back(b); else exp1.push_back(b);
        end
        for (int i = 0; i < len; i++) begin
            if (port == 0) begin
                s0_if.tdata = base + i; s0_if.tlast = (i == len - 1); s0_if.tvalid = 1'b1;
            end else begin
                s1_if.tdata = base + i; s1_if.tlast = (i == len - 1); s1_if.tvalid = 1'b1;
            end
            acc = 0;
            t   = 0;
            while (!acc && t < 2000) begin
                @(negedge ce_clk);
                acc = (port == 0) ? s0_if.tready : s1_if.tready;
                tick();
                t++;
            end
            check("beat_accepted", acc, 1);
            if (!acc) break;
        end
        if (port == 0) s0_if.tvalid = 1'b0; else s1_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((exp0.size() != 0 || exp1.size() != 0 || inflight != 0) && t < 5000) begin
            tick();
            t++;
        end
        check({tag, "_drain_beats"}, exp0.size() + exp1.size(), 0);
        check({tag, "_drain_inflight"}, inflight, 0);
    endtask

    task automatic check_grants(input string tag, input int n_pkts, input bit exact_gap);
        int          pk = 0;
        int unsigned last_cyc = 0;
        foreach (glog[i]) begin
            if (glog[i].first) begin
                check({tag, "_grant_port"}, glog[i].port, pk % 2);
                if (pk > 0) begin
                    if (exact_gap) check({tag, "_bubble"}, glog[i].cyc - last_cyc, 2);
                    else           check({tag, "_bubble_min"}, (glog[i].cyc - last_cyc) >= 2, 1);
                end
                pk++;
            end
            if (glog[i].last) last_cyc = glog[i].cyc;
        end
        check({tag, "_packets"}, pk, n_pkts);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_inflight"}, inflight, 0);
        check({tag, "_c_tvalid"}, c_if.tvalid, 0);
        check({tag, "_s0_tready"}, s0_if.tready, 0);
        check({tag, "_s1_tready"}, s1_if.tready, 0);
        check({tag, "_r_tready"}, r_if.tready, 0);
        check({tag, "_o0_tvalid"}, o0_if.tvalid, 0);
        check({tag, "_o1_tvalid"}, o1_if.tvalid, 0);
    endtask

    task automatic do_reset();
        ce_rst = 1'b1;
        tick();
        tick();
        ce_rst = 1'b0;
        tick();
    endtask

    task automatic apply_stimulus();
        // Reset state
        check_idle("reset");
        ce_rst = 1'b0;
        c_if.tready = 1'b1; o0_if.tready = 1'b1; o1_if.tready = 1'b1;
        tick();

        // Single requester, packet returns on o0 only
        o1_valid_cycles = 0;
        check("t1_inflight_start", inflight, 0);
        send_pkt(0, 4, 32'hA100_0000);
        check("t1_inflight_mid", inflight, 1);
        wait_drain("t1");
        check("t1_o1_never_valid", o1_valid_cycles, 0);

        // Tag FIFO full: fifth packet waits for a pop plus one cycle
        o0_if.tready = 1'b0;
        for (int k = 0; k < 4; k++) send_pkt(0, 1, 32'hA300_0000 + k);
        check("t3_inflight_full", inflight, 4);
        fork
            send_pkt(0, 1, 32'hA300_0004);
            begin
                repeat (12) tick();
                check("t3_stall_tready", s0_if.tready, 0);
                check("t3_stall_busy", busy, 0);
                check("t3_stall_inflight", inflight, 4);
                o0_if.tready = 1'b1;
                #1;
                check("t3_pop_cycle_tready", s0_if.tready, 0);
                tick();
                check("t3_after_pop_tready", s0_if.tready, 0);
                check("t3_after_pop_busy", busy, 0);
                check("t3_after_pop_inflight", inflight, 3);
                tick();
                check("t3_grant_tready", s0_if.tready, 1);
                check("t3_grant_busy", busy, 1);
                check("t3_grant_inflight", inflight, 3);
            end
        join
        wait_drain("t3");

        // Reset in the middle of a GRANT1 packet
        s1_if.tdata = 32'hB500_0000; s1_if.tlast = 1'b0; s1_if.tvalid = 1'b1;
        tick();
        tick();
        check("t5_busy_before", busy, 1);
        check("t5_c_tvalid_before", c_if.tvalid, 1);
        ce_rst = 1'b1;
        #1;
        check_idle("t5_rst");
        s1_if.tvalid = 1'b0;
        tick();
        tick();
        ce_rst = 1'b0;
        tick();
        log_en = 1; glog.delete();
        fork
            send_pkt(0, 1, 32'hA600_0000);
            send_pkt(1, 1, 32'hB600_0000);
        join
        wait_drain("t5");
        log_en = 0;
        check_grants("t5", 2, 1);

        // Both requesters valid from reset, 3-beat packets
        do_reset();
        log_en = 1; glog.delete();
        fork
            begin send_pkt(0, 3, 32'hA200_0000); send_pkt(0, 3, 32'hA210_0000); end
            begin send_pkt(1, 3, 32'hB200_0000); send_pkt(1, 3, 32'hB210_0000); end
        join
        wait_drain("t2");
        log_en = 0;
        check_grants("t2", 4, 1);

        // Back-to-back 1-beat packets from both ports
        do_reset();
        log_en = 1; glog.delete();
        fork
            for (int k = 0; k < 6; k++) send_pkt(0, 1, 32'hA800_0000 + k);
            for (int k = 0; k < 6; k++) send_pkt(1, 1, 32'hB800_0000 + k);
        join
        wait_drain("t6");
        log_en = 0;
        check_grants("t6", 12, 0);

        // Random readiness, 1000 packets of 1-16 beats
        rnd_mode = 1;
        fork
            for (int k = 0; k < 500; k++) send_pkt(0, $urandom_range(1, 16), 32'hA700_0000 + (k << 8));
            for (int k = 0; k < 500; k++) send_pkt(1, $urandom_range(1, 16), 32'hB700_0000 + (k << 8));
        join
        rnd_mode = 0;
        tick();
        c_if.tready = 1'b1; o0_if.tready = 1'b1; o1_if.tready = 1'b1;
        wait_drain("rnd");
        check("push_pop_same_cycle_seen", samecyc > 0, 1);
    endtask

    initial begin
        s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
        c_if.tready  = 1'b0; o0_if.tready = 1'b0; o1_if.tready = 1'b0;
        r_if.tvalid  = 1'b0; r_if.tdata = '0; r_if.tlast = 1'b0;
        repeat (3) tick();
        apply_stimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cordic_share_arbiter.md
CORDIC_SHARE_ARBITER -- requirements
Module: cordic_share_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: sample width of all stream ports (SC16 I/Q).
REQ-002 SHALL have parameter TAG_DEPTH_LOG2, default 2: log2 of the maximum number of packets in flight inside the shared CORDIC.
REQ-003 SHALL have port ce_clk, input, 1: the only clock.
REQ-004 SHALL have port ce_rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports s0_tdata/s0_tlast/s0_tvalid/s0_tready, in/in/in/out, WIDTH/1/1/1: requester 0 input stream.
REQ-006 SHALL have ports s1_tdata/s1_tlast/s1_tvalid/s1_tready, in/in/in/out, WIDTH/1/1/1: requester 1 input stream.
REQ-007 SHALL have ports c_tdata/c_tlast/c_tvalid/c_tready, out/out/out/in, WIDTH/1/1/1: stream to the shared CORDIC.
REQ-008 SHALL have ports r_tdata/r_tlast/r_tvalid/r_tready, in/in/in/out, WIDTH/1/1/1: result stream returning from the CORDIC.
REQ-009 SHALL have ports o0_* and o1_* (tdata/tlast/tvalid out, tready in), WIDTH/1/1/1: per-requester result streams.
REQ-010 SHALL have port inflight, output, TAG_DEPTH_LOG2+1: packets granted but not yet fully returned.
REQ-011 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, GRANT0 and GRANT1.
REQ-013 In IDLE with inflight < 2^TAG_DEPTH_LOG2, SHALL move to GRANTx for a requester with sx_tvalid=1.
REQ-014 When both requesters are valid, SHALL grant the port not granted last (round-robin); last_grant SHALL update on every grant.
REQ-015 In IDLE, SHALL hold c_tvalid=0, s0_tready=0 and s1_tready=0.
REQ-016 In GRANTx, SHALL drive c_*=sx_* combinationally and sx_tready=c_tready; the other port's tready SHALL be 0.
REQ-017 SHALL hold the grant for a whole packet and return to IDLE on the cycle after the sx beat with tlast accepted; this gives exactly one bubble cycle per packet.
REQ-018 On each IDLE->GRANTx transition, SHALL push tag x into an internal tag FIFO of depth 2^TAG_DEPTH_LOG2.
REQ-019 SHALL route returning data by the head tag: ox_tvalid=r_tvalid & !empty & (head==x), and r_tready=o_head_tready & !empty.
REQ-020 SHALL pop the tag FIFO when a return beat with r_tlast is accepted.
REQ-021 When the tag FIFO is empty, SHALL hold r_tready=0 and both o_tvalid=0.
REQ-022 When the tag FIFO is full, SHALL make no grant; on a same-cycle pop, the grant SHALL still wait one cycle, because full is evaluated on the registered count.
REQ-023 On a simultaneous push and pop, inflight SHALL be unchanged; push alone SHALL add 1, pop alone SHALL subtract 1; read and write pointers SHALL wrap modulo depth.
REQ-024 SHALL not modify tdata or tlast in either direction.
REQ-025 SHALL add zero latency on all paths; the only registered elements are the FSM, last_grant, the tag FIFO and the count.

Reset
REQ-026 On ce_rst, state=IDLE, last_grant=1 (port 0 wins the first tie), pointers=0, inflight=0 and busy=0.
REQ-027 During and after reset, all treadies and tvalids SHALL be 0 until the REQ-013/REQ-019 conditions hold.
REQ-028 Reset mid-packet SHALL abandon the packet; recovery of data already in the CORDIC is the integrator's responsibility (reset the CORDIC together with this block).

Structure
REQ-029 A shared package SHALL hold the FSM state encodings (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and the port-index constants.
REQ-030 The tag FIFO SHALL be the single sub-module, tag_fifo: 1-bit wide, depth 2^TAG_DEPTH_LOG2, with full, empty and count outputs.

Verification
REQ-031 Only s0 sends a 4-beat packet, c_tready=1, CORDIC modelled as an 8-cycle delay line -> the packet appears on o0 unchanged, o1 never valid, inflight goes 0->1->0.
REQ-032 s0 and s1 are both valid from reset with 3-beat packets -> grant order 0,1,0,1; exactly one idle c_tvalid cycle between packets; each result reaches the matching output.
REQ-033 TAG_DEPTH_LOG2=2, r_tready held off by o0_tready=0, five packets offered -> four granted, the fifth stalls with sx_tready=0 until a pop, then is granted one cycle later.
REQ-034 Random c_tready, o0_tready and o1_tready (50%) over 1000 packets of lengths 1-16 -> no beat lost, duplicated or misrouted, and packet order is preserved per port.
REQ-035 ce_rst asserted in the middle of a GRANT1 packet -> all outputs immediately idle, inflight=0, and after release the first tie goes to port 0.
REQ-036 1-beat packets from both ports back-to-back -> each tlast beat returns to IDLE, and push/pop in the same cycle leaves inflight constant.
